// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared constants, divisor field type and the
// half-period helper used by the clock-enable generator.
package clk_gen_pkg;

  localparam int DIV_W_DEF     = 8;
  localparam int DIV_RESET_DEF = 1;

  typedef logic [DIV_W_DEF-1:0] div_field_t;

  // Start of the low half: ceil(n/2), so odd periods run
  // one cycle longer high than low.
  function automatic int unsigned half_point(
    input int unsigned n
  );
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel. Ports: clk_i, rst_i,
// en_i, sync_i, div_i/inv_i/load_i in; tick/half/clk_div/pend out.
module clk_div_channel
  import clk_gen_pkg::*;
#(
  parameter int DIV_W     = DIV_W_DEF,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             inv_i,
  input  logic             load_i,
  output logic             tick_o,
  output logic             half_o,
  output logic             clk_div_o,
  output logic             pend_o
);

  typedef logic [DIV_W-1:0] fld_t;
  typedef logic [DIV_W:0]   wide_t;

  localparam fld_t D_RST = fld_t'(DIV_RESET);

  fld_t  cnt, d, pd;
  logic  p, pp;

  fld_t  cnt_nx, d_nx;
  logic  p_nx, step, wrap;
  wide_t h_nx;

  always_comb begin
    step = sync_i | en_i;
    if (sync_i)
      cnt_nx = '0;
    else if (en_i && cnt == d)
      cnt_nx = '0;
    else if (en_i)
      cnt_nx = cnt + 1'b1;
    else
      cnt_nx = cnt;

    wrap = step && (cnt_nx == '0);

    // A load coinciding with a wrap beats the older pending value.
    d_nx = d;
    p_nx = p;
    if (wrap && load_i) begin
      d_nx = div_i;
      p_nx = inv_i;
    end else if (wrap && pend_o) begin
      d_nx = pd;
      p_nx = pp;
    end

    h_nx = wide_t'(half_point(32'(d_nx) + 32'd1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= D_RST;
      d         <= D_RST;
      p         <= 1'b0;
      pd        <= D_RST;
      pp        <= 1'b0;
      pend_o    <= 1'b0;
      tick_o    <= 1'b0;
      half_o    <= 1'b0;
      clk_div_o <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      d   <= d_nx;
      p   <= p_nx;
      if (load_i) begin
        pd <= div_i;
        pp <= inv_i;
      end
      if (wrap)
        pend_o <= 1'b0;
      else if (load_i)
        pend_o <= 1'b1;
      tick_o <= wrap;
      half_o <= step && (d_nx != '0)
                && ({1'b0, cnt_nx} == h_nx);
      if (step)
        clk_div_o <= ({1'b0, cnt_nx} < h_nx) ^ p_nx;
    end
  end

endmodule

// File: rtl/clk_phase_gen.sv
// clk_phase_gen: CHANNELS independent clock-enable dividers
// sharing clk_i, rst_i and sync_i; per-channel buses elsewhere.
module clk_phase_gen
  import clk_gen_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic                      sync_i,
  input  logic [CHANNELS*DIV_W-1:0] div_i,
  input  logic [CHANNELS-1:0]       inv_i,
  input  logic [CHANNELS-1:0]       load_i,
  output logic [CHANNELS-1:0]       tick_o,
  output logic [CHANNELS-1:0]       half_o,
  output logic [CHANNELS-1:0]       clk_div_o,
  output logic [CHANNELS-1:0]       pend_o
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    clk_div_channel #(
      .DIV_W     (DIV_W),
      .DIV_RESET (DIV_RESET)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i[k]),
      .sync_i    (sync_i),
      .div_i     (div_i[k*DIV_W +: DIV_W]),
      .inv_i     (inv_i[k]),
      .load_i    (load_i[k]),
      .tick_o    (tick_o[k]),
      .half_o    (half_o[k]),
      .clk_div_o (clk_div_o[k]),
      .pend_o    (pend_o[k])
    );
  end

endmodule

// File: tb/tb_clk_phase_gen.sv
// tb_clk_phase_gen: scenario tasks plus randomized traffic,
// checked against a period-position reference model.
module tb_clk_phase_gen;

  localparam int CH = 2;
  localparam int W  = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            sync_i;
  logic [CH-1:0]   en_i, inv_i, load_i;
  logic [CH*W-1:0] div_i;
  logic [CH-1:0]   tick_o, half_o, clk_div_o, pend_o;

  always #5 clk_i = ~clk_i;

  clk_phase_gen #(
    .CHANNELS  (CH),
    .DIV_W     (W),
    .DIV_RESET (1)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .sync_i    (sync_i),
    .div_i     (div_i),
    .inv_i     (inv_i),
    .load_i    (load_i),
    .tick_o    (tick_o),
    .half_o    (half_o),
    .clk_div_o (clk_div_o),
    .pend_o    (pend_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: position within the period, period length, polarity.
  int      m_pos [CH];
  int      m_n   [CH];
  int      m_pn  [CH];
  bit      m_p   [CH];
  bit      m_pp  [CH];
  bit      m_pend[CH];
  logic [CH-1:0] e_tick, e_half, e_clk, e_pend;

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_n[k]    = 2;
      m_pos[k]  = 1;
      m_p[k]    = 0;
      m_pn[k]   = 2;
      m_pp[k]   = 0;
      m_pend[k] = 0;
    end
    e_tick = '0;
    e_half = '0;
    e_clk  = '0;
    e_pend = '0;
  endtask

  task automatic model_step();
    for (int k = 0; k < CH; k++) begin
      bit st, wr;
      int h, dv;
      st = sync_i || en_i[k];
      if (sync_i)
        m_pos[k] = 0;
      else if (en_i[k])
        m_pos[k] = (m_pos[k] + 1) % m_n[k];
      wr = st && (m_pos[k] == 0);
      dv = int'(div_i[k*W +: W]) + 1;
      if (wr) begin
        if (load_i[k]) begin
          m_n[k] = dv;
          m_p[k] = inv_i[k];
        end else if (m_pend[k]) begin
          m_n[k] = m_pn[k];
          m_p[k] = m_pp[k];
        end
        m_pend[k] = 0;
      end else if (load_i[k]) begin
        m_pn[k]   = dv;
        m_pp[k]   = inv_i[k];
        m_pend[k] = 1;
      end
      h = (m_n[k] + 1) / 2;
      e_tick[k] = wr;
      e_half[k] = st && m_n[k] >= 2 && m_pos[k] == h;
      if (st)
        e_clk[k] = (m_pos[k] < h) ^ m_p[k];
      e_pend[k] = m_pend[k];
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    if (rst_i)
      model_reset();
    else
      model_step();
    #1;
  endtask

  task automatic set_div(input int k, input int d,
                         input bit inv);
    div_i[k*W +: W] = W'(d);
    inv_i[k]        = inv;
    load_i[k]       = 1'b1;
  endtask

  task automatic test_reset();
    rst_i  = 1'b1;
    sync_i = 1'b0;
    en_i   = '0;
    inv_i  = '0;
    load_i = '0;
    div_i  = '0;
    #12;
    model_reset();
    n_cmp++;
    if ({tick_o, half_o, clk_div_o, pend_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 0",
               {tick_o, half_o, clk_div_o, pend_o});
    end
    rst_i = 1'b0;
    en_i  = '1;
  endtask

  task automatic test_n2();
    logic [2:0] want;
    for (int i = 0; i < 8; i++) begin
      adv();
      want = (i % 2 == 0) ? 3'b101 : 3'b010;
      n_cmp++;
      if ({tick_o[0], half_o[0], clk_div_o[0]} !== want) begin
        n_bad++;
        $display("FAIL n2_pattern cyc %0d: got %b want %b", i,
                 {tick_o[0], half_o[0], clk_div_o[0]}, want);
      end
      n_cmp++;
      if ({tick_o, half_o, clk_div_o, pend_o}
          !== {e_tick, e_half, e_clk, e_pend}) begin
        n_bad++;
        $display("FAIL n2_model: got %b want %b",
                 {tick_o, half_o, clk_div_o, pend_o},
                 {e_tick, e_half, e_clk, e_pend});
      end
    end
  endtask

  task automatic test_load_n5();
    int last, gap;
    adv();
    if (m_pos[0] != 0) adv();
    set_div(0, 4, 1'b0);
    adv();
    load_i = '0;
    n_cmp++;
    if (pend_o[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL n5_pend: got %b want 1", pend_o[0]);
    end
    last = -1;
    gap  = 0;
    for (int i = 0; i < 20; i++) begin
      adv();
      if (tick_o[0]) begin
        if (last >= 0) gap = i - last;
        last = i;
      end
      n_cmp++;
      if ({tick_o, half_o, clk_div_o, pend_o}
          !== {e_tick, e_half, e_clk, e_pend}) begin
        n_bad++;
        $display("FAIL n5_model cyc %0d: got %b want %b", i,
                 {tick_o, half_o, clk_div_o, pend_o},
                 {e_tick, e_half, e_clk, e_pend});
      end
    end
    n_cmp++;
    if (gap != 5) begin
      n_bad++;
      $display("FAIL n5_period: got %0d want 5", gap);
    end
  endtask

  task automatic test_n1_inv();
    set_div(0, 0, 1'b1);
    adv();
    load_i = '0;
    for (int i = 0; i < 12; i++) begin
      adv();
      n_cmp++;
      if ({tick_o, half_o, clk_div_o, pend_o}
          !== {e_tick, e_half, e_clk, e_pend}) begin
        n_bad++;
        $display("FAIL n1_model cyc %0d: got %b want %b", i,
                 {tick_o, half_o, clk_div_o, pend_o},
                 {e_tick, e_half, e_clk, e_pend});
      end
      if (i >= 8) begin
        n_cmp++;
        if ({tick_o[0], half_o[0], clk_div_o[0]} !== 3'b100)
        begin
          n_bad++;
          $display("FAIL n1_inv cyc %0d: got %b want 100", i,
                   {tick_o[0], half_o[0], clk_div_o[0]});
        end
      end
    end
  endtask

  task automatic test_enable_gaps();
    bit found;
    bit pat [5] = '{1, 1, 0, 0, 1};
    bit tk  [5] = '{0, 0, 0, 0, 1};
    set_div(0, 2, 1'b0);
    adv();
    load_i = '0;
    found  = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      adv();
      if (m_n[0] == 3 && tick_o[0]) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL en_align: no tick with N=3 in 20 cycles");
    end
    for (int i = 0; i < 5; i++) begin
      en_i[0] = pat[i];
      adv();
      n_cmp++;
      if ({tick_o[0], half_o[0] & ~pat[i]}
          !== {tk[i], 1'b0}) begin
        n_bad++;
        $display("FAIL en_gap cyc %0d: got %b%b want %b0", i,
                 tick_o[0], half_o[0], tk[i]);
      end
      n_cmp++;
      if ({tick_o, half_o, clk_div_o, pend_o}
          !== {e_tick, e_half, e_clk, e_pend}) begin
        n_bad++;
        $display("FAIL en_model cyc %0d: got %b want %b", i,
                 {tick_o, half_o, clk_div_o, pend_o},
                 {e_tick, e_half, e_clk, e_pend});
      end
    end
    en_i = '1;
  endtask

  task automatic test_sync();
    int cyc;
    en_i = '0;
    set_div(0, 7, 1'b0);
    adv();
    load_i = '0;
    adv();
    n_cmp++;
    if ({tick_o, half_o, pend_o[0]} !== {{2*CH{1'b0}}, 1'b1})
    begin
      n_bad++;
      $display("FAIL sync_idle: got %b want pend only",
               {tick_o, half_o, pend_o});
    end
    sync_i = 1'b1;
    adv();
    sync_i = 1'b0;
    n_cmp++;
    if ({tick_o, pend_o[0]} !== {{CH{1'b1}}, 1'b0}) begin
      n_bad++;
      $display("FAIL sync_tick: got %b want all tick, no pend",
               {tick_o, pend_o[0]});
    end
    en_i = '1;
    cyc  = 0;
    do begin
      adv();
      cyc++;
    end while (!tick_o[0] && cyc < 20);
    n_cmp++;
    if (cyc != 8) begin
      n_bad++;
      $display("FAIL sync_period: got %0d want 8", cyc);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    set_div(0, 4, 1'b0);
    adv();
    load_i = '0;
    guard  = 0;
    while (!(m_n[0] == 5 && m_pos[0] == 1) && guard < 30) begin
      adv();
      guard++;
    end
    n_cmp++;
    if (clk_div_o[0] !== 1'b1 || guard >= 30) begin
      n_bad++;
      $display("FAIL rst_setup: clk_div %b guard %0d",
               clk_div_o[0], guard);
    end
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if ({tick_o, half_o, clk_div_o, pend_o} !== '0) begin
      n_bad++;
      $display("FAIL rst_async: got %b want 0",
               {tick_o, half_o, clk_div_o, pend_o});
    end
    adv();
    rst_i = 1'b0;
    adv();
    n_cmp++;
    if (tick_o !== '1) begin
      n_bad++;
      $display("FAIL rst_first_tick: got %b want 11", tick_o);
    end
    adv();
    n_cmp++;
    if ({tick_o, half_o} !== {{CH{1'b0}}, {CH{1'b1}}}) begin
      n_bad++;
      $display("FAIL rst_n2_half: got %b want 0011",
               {tick_o, half_o});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en_i   = CH'($urandom);
      sync_i = ($urandom_range(39) == 0);
      for (int k = 0; k < CH; k++) begin
        load_i[k] = ($urandom_range(7) == 0);
        div_i[k*W +: W] = W'($urandom_range(9));
        inv_i[k] = $urandom_range(1) == 1;
      end
      adv();
      n_cmp++;
      if ({tick_o, half_o, clk_div_o, pend_o}
          !== {e_tick, e_half, e_clk, e_pend}) begin
        n_bad++;
        $display("FAIL rand_model cyc %0d: got %b want %b", i,
                 {tick_o, half_o, clk_div_o, pend_o},
                 {e_tick, e_half, e_clk, e_pend});
      end
    end
    load_i = '0;
    sync_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_n2();
    test_load_n5();
    test_n1_inv();
    test_enable_gaps();
    test_sync();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
